// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch FSM states and default widths/reset PC for the 16-bit CPU
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory read channel (valid/ready request, single-beat response)
interface fetch_unit_if #(
  parameter int ADDR_W = cpu_pkg::DEF_ADDR_W,
  parameter int DATA_W = cpu_pkg::DEF_DATA_W
);
  logic mem_req_valid;
  logic mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  modport master (output mem_req_valid, mem_req_addr, input mem_req_ready, mem_rsp_valid, mem_rsp_data);
  modport slave (input mem_req_valid, mem_req_addr, output mem_req_ready, mem_rsp_valid, mem_rsp_data);
endinterface

// File: rtl/pc_next.sv
// pc_next: next program counter -- live redirect, pending redirect target or sequential step
module pc_next import cpu_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PC_STEP = 1
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic idle,
  input  logic done,
  input  logic kill,
  input  logic redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [ADDR_W-1:0] pend_pc,
  output logic [ADDR_W-1:0] nxt
);
  always_comb nxt = redirect_valid && (idle || done) ? redirect_pc :
                    !done ? pc :
                    kill ? pend_pc : pc + ADDR_W'(PC_STEP);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC and single-outstanding instruction fetch feeding the IR.
// Define FETCH_COUNT_EN to add the fetch_count output (delivered words, wrapping).
module fetch_unit import cpu_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int PC_STEP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic stall,
  input  logic redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_unit_if.master mem,
  output logic [DATA_W-1:0] ir_data,
  output logic ir_load,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc,
  output logic busy
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0] fetch_count
`endif
);
  fetch_state_t state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt, pend_pc;
  logic kill, done, deliver;
  assign done = state == WAIT && mem.mem_rsp_valid;
  assign deliver = done && !kill && !redirect_valid;
  assign mem.mem_req_valid = state == REQ;
  assign mem.mem_req_addr = pc;
  assign busy = state != IDLE;
  pc_next #(.ADDR_W(ADDR_W), .PC_STEP(PC_STEP)) u_pc_next (
    .pc(pc),
    .idle(state == IDLE),
    .done(done),
    .kill(kill),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .pend_pc(pend_pc),
    .nxt(pc_nxt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = en && !stall && !redirect_valid ? REQ : IDLE;
      REQ: state_nxt = mem.mem_req_ready ? WAIT : REQ;
      WAIT: state_nxt = !mem.mem_rsp_valid ? WAIT : en && !stall ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // a redirect while a fetch is outstanding is parked until that fetch's response retires
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc <= RESET_PC;
      pend_pc <= '0;
      kill <= 1'b0;
      ir_data <= '0;
      instr_pc <= '0;
      ir_load <= 1'b0;
    end else begin
      pc <= pc_nxt;
      ir_load <= deliver;
      if (deliver) begin
        ir_data <= mem.mem_rsp_data;
        instr_pc <= pc;
      end
      if (redirect_valid && busy && !done) begin
        pend_pc <= redirect_pc;
        kill <= 1'b1;
      end else if (done) kill <= 1'b0;
    end
`ifdef FETCH_COUNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) fetch_count <= '0;
    else if (deliver) fetch_count <= fetch_count + 16'd1;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random checks of fetch_unit against a program-order fetch model
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] ir_data, instr_pc, pc;
  logic ir_load, busy;
  int n_cmp = 0, n_err = 0;
  fetch_unit_if mem ();
`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif
  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .mem(mem),
    .ir_data(ir_data),
    .ir_load(ir_load),
    .instr_pc(instr_pc),
    .pc(pc),
    .busy(busy)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // memory: ready after rdy_lat refused cycles, response rsp_lat cycles after the 1-cycle minimum
  int rdy_lat = 0, rsp_lat = 0, wcnt = 0, rcnt = 0;
  bit pend = 0, acc_next = 0;
  logic [15:0] acc_addr, pend_addr;
  logic [15:0] acc_q[$];
  always @(negedge clk) begin
    mem.mem_rsp_valid = 1'b0;
    mem.mem_rsp_data = 16'($urandom);
    if (acc_next) begin
      pend = 1;
      pend_addr = acc_addr;
      rcnt = rsp_lat;
      acc_q.push_back(acc_addr);
    end
    if (pend) begin
      if (rcnt == 0) begin
        mem.mem_rsp_valid = 1'b1;
        mem.mem_rsp_data = pend_addr ^ 16'hA5A5;
        pend = 0;
      end else rcnt--;
    end
    acc_next = 0;
    mem.mem_req_ready = 1'b0;
    if (mem.mem_req_valid) begin
      mem.mem_req_ready = wcnt >= rdy_lat;
      wcnt = mem.mem_req_ready ? 0 : wcnt + 1;
      acc_next = mem.mem_req_ready;
      acc_addr = mem.mem_req_addr;
    end
  end

  // model: loads must walk program order from the last redirect target
  logic [15:0] exp_pc = '0;
  int loads = 0;
  bit p_valid = 0, p_load = 0;
  logic [15:0] p_addr = '0;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      p_valid = 0;
      p_load = 0;
    end else begin
      if (ir_load) begin
        chk("load_pc", instr_pc, exp_pc);
        chk("load_data", ir_data, exp_pc ^ 16'hA5A5);
        chk("load_single_cycle", p_load, 0);
        exp_pc = exp_pc + 16'd1;
        loads++;
      end
      if (p_valid && !mem.mem_req_ready) begin
        chk("req_held_valid", mem.mem_req_valid, 1);
        chk("req_held_addr", mem.mem_req_addr, p_addr);
      end
      p_valid = mem.mem_req_valid;
      p_addr = mem.mem_req_addr;
      p_load = ir_load;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drain();
    int n = 0;
    while (busy && n < 50) begin tick(1); n++; end
    chk("drain_idle", busy, 0);
    tick(2);
  endtask
  task automatic wait_load();
    int n = 0;
    while (ir_load !== 1'b1 && n < 50) begin tick(1); n++; end
    chk("load_seen", ir_load, 1);
  endtask
  task automatic wait_wait_state();
    int n = 0;
    while (!(busy && !mem.mem_req_valid) && n < 50) begin tick(1); n++; end
    chk("wait_state_seen", busy && !mem.mem_req_valid, 1);
  endtask
  task automatic wait_req();
    int n = 0;
    while (mem.mem_req_valid !== 1'b1 && n < 50) begin tick(1); n++; end
    chk("req_seen", mem.mem_req_valid, 1);
  endtask
  task automatic redirect_idle(input logic [15:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    exp_pc = t;
    tick(1);
    redirect_valid = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, mem.mem_req_valid, 0);
    chk({tag, "_load"}, ir_load, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ir_data"}, ir_data, 0);
    chk({tag, "_instr_pc"}, instr_pc, 0);
    chk({tag, "_pc"}, pc, 16'h0000);
`ifdef FETCH_COUNT_EN
    chk({tag, "_fetch_count"}, fetch_count, 0);
`endif
  endtask

  initial begin
    int l0;
    tick(2);
    chk_reset("reset");
    // back-to-back fetch, 1-cycle memory
    en = 1'b1;
    rst = 1'b1;
    tick(1);
    chk("t1_req_valid", mem.mem_req_valid, 1);
    chk("t1_req_addr", mem.mem_req_addr, 16'h0000);
    tick(1);
    chk("t1_wait_busy", busy, 1);
    tick(1);
    chk("t1_load0", ir_load, 1);
    chk("t1_word0", ir_data, 16'hA5A5);
    chk("t1_next_req", mem.mem_req_valid, 1);
    tick(1);
    chk("t1_load_gap", ir_load, 0);
    tick(1);
    chk("t1_load1", ir_load, 1);
    chk("t1_word1", ir_data, 16'hA5A4);
    chk("t1_pc", pc, 16'h0002);
    en = 1'b0;
    drain();
`ifdef FETCH_COUNT_EN
    chk("t1_fetch_count", fetch_count, 3);
`endif
    // ready withheld three cycles
    redirect_idle(16'h0000);
    en = 1'b1;
    rdy_lat = 3;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t2_hold_valid", mem.mem_req_valid, 1);
      chk("t2_hold_addr", mem.mem_req_addr, 16'h0000);
      en = 1'b0;
    end
    rdy_lat = 0;
    tick(1);
    chk("t2_no_early_load", ir_load, 0);
    tick(1);
    chk("t2_delayed_load", ir_load, 1);
    drain();
    // redirect during WAIT drops the in-flight word
    rsp_lat = 2;
    en = 1'b1;
    wait_wait_state();
    redirect_valid = 1'b1;
    redirect_pc = 16'h1234;
    exp_pc = 16'h1234;
    l0 = loads;
    tick(1);
    redirect_valid = 1'b0;
    wait_req();
    chk("t3_redirect_addr", mem.mem_req_addr, 16'h1234);
    en = 1'b0;
    tick(1);
    wait_load();
    chk("t3_instr_pc", instr_pc, 16'h1234);
    chk("t3_one_load", loads, l0 + 1);
    drain();
    chk("t3_pc", pc, 16'h1235);
    // address wrap
    rsp_lat = 0;
    redirect_idle(16'hFFFF);
    acc_q.delete();
    en = 1'b1;
    wait_load();
    chk("t4_wrap_req", mem.mem_req_addr, 16'h0000);
    en = 1'b0;
    tick(1);
    wait_load();
    drain();
    chk("t4_accepts", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("t4_addr0", acc_q[0], 16'hFFFF);
      chk("t4_addr1", acc_q[1], 16'h0000);
    end
    chk("t4_pc", pc, 16'h0001);
    // stall in WAIT lets the word load but blocks the next request
    rsp_lat = 2;
    en = 1'b1;
    wait_wait_state();
    stall = 1'b1;
    wait_load();
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("t5_stalled", mem.mem_req_valid, 0);
    end
    stall = 1'b0;
    tick(1);
    chk("t5_resume", mem.mem_req_valid, 1);
    en = 1'b0;
    drain();
    // random en/stall/redirect/latency mix
    for (int i = 0; i < 500; i++) begin
      rdy_lat = $urandom_range(0, 3);
      rsp_lat = $urandom_range(0, 3);
      en = $urandom_range(0, 7) != 0;
      stall = $urandom_range(0, 5) == 0;
      redirect_valid = $urandom_range(0, 9) == 0;
      if (redirect_valid) begin
        redirect_pc = 16'($urandom);
        exp_pc = redirect_pc;
      end
      tick(1);
    end
    redirect_valid = 1'b0;
    stall = 1'b0;
    en = 1'b0;
    rdy_lat = 0;
    drain();
    chk("rand_pc", pc, exp_pc);
    // reset in WAIT, late response ignored
    rsp_lat = 3;
    en = 1'b1;
    wait_wait_state();
    rst = 1'b0;
    en = 1'b0;
    exp_pc = 16'h0000;
    #1;
    chk_reset("t7_reset");
    tick(1);
    rst = 1'b1;
    l0 = loads;
    tick(8);
    chk("t7_late_rsp_ignored", loads, l0);
    chk("t7_idle", busy, 0);
    rsp_lat = 0;
    en = 1'b1;
    wait_load();
    en = 1'b0;
    tick(1);
    wait_load();
    drain();
    chk("t7_two_loads", loads, l0 + 2);
`ifdef FETCH_COUNT_EN
    chk("t7_fetch_count", fetch_count, 2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
